// File: rtl/serial_frame_codec.sv
// Framed-packet codec: parses SOF/LEN/payload/CSUM frames, answers ACK/NAK, then replays verified payload.
// Optional inter-byte timeout is enabled with `define SERIAL_FRAME_TIMEOUT_EN.
module serial_frame_codec #(
    parameter int          MAX_LEN        = 16,
    parameter logic [7:0]  SOF_BYTE       = 8'hA5,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] pl_data,
    output logic       pl_valid,
    output logic       pl_last,
    input  logic       pl_ready,
    output logic       frame_err,
    output logic [7:0] err_count
);

    localparam int         IDX_W     = $clog2(MAX_LEN + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
        $error("serial_frame_codec: MAX_LEN must be 1..255");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("serial_frame_codec: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] len;
    logic [IDX_W-1:0] last_idx;
    logic [IDX_W-1:0] next_idx;
    logic [7:0]       csum;
    logic             good;
    logic [7:0]       buffer [MAX_LEN];

    logic rx_fire;
    logic tx_fire;
    logic pl_fire;
    logic ack_now;
    logic nak_now;
    logic timeout;
    logic in_frame;

    assign rx_fire  = rx_valid && rx_ready;
    assign tx_fire  = tx_valid && tx_ready;
    assign pl_fire  = pl_valid && pl_ready;
    assign last_idx = len - IDX_W'(1);
    assign next_idx = idx + IDX_W'(1);
    assign in_frame = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);

`ifdef SERIAL_FRAME_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [TO_W-1:0] to_count;

    // Counts idle cycles only while a frame is partially received.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_count <= '0;
        end else if (rx_fire || !in_frame) begin
            to_count <= '0;
        end else begin
            to_count <= to_count + TO_W'(1);
        end
    end

    assign timeout = in_frame && !rx_fire && (to_count == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Both response decisions funnel through ack_now/nak_now so RESP entry lives in one place.
    always_comb begin
        ack_now = 1'b0;
        nak_now = 1'b0;
        if (rx_fire && state == S_LEN && (rx_data == 8'd0 || rx_data > MAX_LEN_B)) begin
            nak_now = 1'b1;
        end
        if (rx_fire && state == S_CSUM) begin
            if (rx_data == csum) begin
                ack_now = 1'b1;
            end else begin
                nak_now = 1'b1;
            end
        end
        if (timeout) begin
            nak_now = 1'b1;
        end
    end

    // Payload storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && rx_fire) begin
            buffer[idx] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rx_ready  <= 1'b1;
            tx_valid  <= 1'b0;
            tx_data   <= 8'd0;
            pl_valid  <= 1'b0;
            pl_last   <= 1'b0;
            pl_data   <= 8'd0;
            frame_err <= 1'b0;
            err_count <= 8'd0;
            idx       <= '0;
            len       <= '0;
            csum      <= 8'd0;
            good      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (ack_now || nak_now) begin
                state    <= S_RESP;
                rx_ready <= 1'b0;
                tx_valid <= 1'b1;
                tx_data  <= ack_now ? ACK_BYTE : NAK_BYTE;
                good     <= ack_now;
                if (nak_now) begin
                    frame_err <= 1'b1;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rx_fire && rx_data == SOF_BYTE) begin
                            state <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (rx_fire) begin
                            len   <= IDX_W'(rx_data);
                            csum  <= rx_data;
                            idx   <= '0;
                            state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        if (rx_fire) begin
                            csum <= csum ^ rx_data;
                            idx  <= next_idx;
                            if (idx == last_idx) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        state <= S_CSUM;
                    end
                    S_RESP: begin
                        if (tx_fire) begin
                            tx_valid <= 1'b0;
                            if (good) begin
                                state    <= S_DRAIN;
                                idx      <= '0;
                                pl_valid <= 1'b1;
                                pl_data  <= buffer[0];
                                pl_last  <= (len == IDX_W'(1));
                            end else begin
                                state    <= S_IDLE;
                                rx_ready <= 1'b1;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (pl_fire) begin
                            if (pl_last) begin
                                pl_valid <= 1'b0;
                                pl_last  <= 1'b0;
                                state    <= S_IDLE;
                                rx_ready <= 1'b1;
                            end else begin
                                idx     <= next_idx;
                                pl_data <= buffer[next_idx];
                                pl_last <= (next_idx == last_idx);
                            end
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        rx_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_codec.sv
// Self-checking bench for serial_frame_codec: directed scenarios plus random frames against a stream-level parser model.
// Honours `define SERIAL_FRAME_TIMEOUT_EN to choose the expected timeout behaviour.
module tb_serial_frame_codec;

    localparam int MAX_LEN = 16;
    localparam int TO_CYC  = 100;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_last;
    logic       pl_ready;
    logic       frame_err;
    logic [7:0] err_count;

    serial_frame_codec #(
        .MAX_LEN       (MAX_LEN),
        .SOF_BYTE      (8'hA5),
        .ACK_BYTE      (8'h06),
        .NAK_BYTE      (8'h15),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .pl_data  (pl_data),
        .pl_valid (pl_valid),
        .pl_last  (pl_last),
        .pl_ready (pl_ready),
        .frame_err(frame_err),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int stab_err = 0;
    int cap_ferr = 0;
    int exp_naks = 0;
    int exp_err = 0;
    bit rand_ready = 1'b0;
    bit all_accepted;

    logic [7:0] cap_tx[$];
    logic [7:0] exp_tx[$];
    logic [8:0] cap_pl[$];
    logic [8:0] exp_pl[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Monitor: records transfers that will complete on the coming edge and checks held outputs stay put.
    logic       tx_hold, pl_hold;
    logic [7:0] tx_prev;
    logic [8:0] pl_prev;
    always @(negedge clk) begin
        if (rst) begin
            tx_hold = 1'b0;
            pl_hold = 1'b0;
        end else begin
            if (tx_hold && !(tx_valid && tx_data == tx_prev)) stab_err++;
            if (pl_hold && !(pl_valid && {pl_last, pl_data} == pl_prev)) stab_err++;
            if (tx_valid && tx_ready) cap_tx.push_back(tx_data);
            if (pl_valid && pl_ready) cap_pl.push_back({pl_last, pl_data});
            if (frame_err) cap_ferr++;
            tx_hold = tx_valid && !tx_ready;
            pl_hold = pl_valid && !pl_ready;
            tx_prev = tx_data;
            pl_prev = {pl_last, pl_data};
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) begin
            tx_ready = ($urandom_range(0, 2) != 0);
            pl_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Reference: walks the byte stream frame by frame and lists the responses and payload it implies.
    task automatic modelStream(input logic [7:0] s[$]);
        int         i;
        int         n;
        logic [7:0] x;
        i = 0;
        while (i < s.size()) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            if (i + 1 >= s.size()) break;
            n = s[i+1];
            if (n == 0 || n > MAX_LEN) begin
                exp_tx.push_back(8'h15);
                exp_naks++;
                exp_err = (exp_err < 255) ? exp_err + 1 : 255;
                i += 2;
                continue;
            end
            if (i + 2 + n >= s.size()) break;
            x = 8'(n);
            for (int k = 0; k < n; k++) x ^= s[i+2+k];
            if (s[i+2+n] == x) begin
                exp_tx.push_back(8'h06);
                for (int k = 0; k < n; k++) exp_pl.push_back({(k == n - 1), s[i+2+k]});
            end else begin
                exp_tx.push_back(8'h15);
                exp_naks++;
                exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            end
            i += n + 3;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] s[$], input int gap_max);
        bit ok;
        all_accepted = 1'b1;
        foreach (s[j]) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            rx_data  = s[j];
            rx_valid = 1'b1;
            ok = 1'b0;
            for (int w = 0; w < 500 && !ok; w++) begin
                @(negedge clk);
                if (rx_ready) ok = 1'b1;
                @(posedge clk);
                #1;
            end
            if (!ok) all_accepted = 1'b0;
        end
        rx_valid = 1'b0;
        checkOutput("rx_accept", all_accepted, 1'b1);
    endtask

    task automatic waitQuiet();
        int quiet;
        quiet = 0;
        for (int c = 0; c < 3000 && quiet < 4; c++) begin
            @(negedge clk);
            if (rx_ready && !tx_valid && !pl_valid) quiet++;
            else quiet = 0;
        end
        @(posedge clk);
        #1;
        checkOutput("settle", (quiet >= 4), 1'b1);
    endtask

    task automatic clearBatch();
        cap_tx.delete();
        exp_tx.delete();
        cap_pl.delete();
        exp_pl.delete();
        cap_ferr = 0;
        exp_naks = 0;
    endtask

    task automatic compareBatch(input string name);
        checkOutput({name, "_tx_count"}, cap_tx.size(), exp_tx.size());
        foreach (exp_tx[j]) if (j < cap_tx.size()) checkOutput({name, "_tx_byte"}, cap_tx[j], exp_tx[j]);
        checkOutput({name, "_pl_count"}, cap_pl.size(), exp_pl.size());
        foreach (exp_pl[j]) if (j < cap_pl.size()) checkOutput({name, "_pl_last_data"}, cap_pl[j], exp_pl[j]);
        checkOutput({name, "_frame_err_cycles"}, cap_ferr, exp_naks);
        checkOutput({name, "_err_count"}, err_count, exp_err);
    endtask

    task automatic runBatch(input string name, input logic [7:0] s[$], input int gap_max);
        clearBatch();
        modelStream(s);
        applyStimulus(s, gap_max);
        waitQuiet();
        compareBatch(name);
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, "_rx_ready"}, rx_ready, 1'b1);
        checkOutput({name, "_tx_valid"}, tx_valid, 1'b0);
        checkOutput({name, "_tx_data"}, tx_data, 8'h00);
        checkOutput({name, "_pl_valid"}, pl_valid, 1'b0);
        checkOutput({name, "_pl_last"}, pl_last, 1'b0);
        checkOutput({name, "_pl_data"}, pl_data, 8'h00);
        checkOutput({name, "_frame_err"}, frame_err, 1'b0);
        checkOutput({name, "_err_count"}, err_count, 8'h00);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkReset("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_err = 0;
    endtask

    logic [7:0] s[$];
    int         seen;
    int         n;
    int         kind;
    logic [7:0] x;
    logic [7:0] b;

    initial begin
        rst      = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        pl_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkReset("init");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] good frame");
        s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        runBatch("good", s, 0);

        $display("[TB] bad checksum");
        s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
        runBatch("badsum", s, 0);

        $display("[TB] invalid lengths");
        s = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'hA5, 8'h11, 8'h56, 8'h78};
        runBatch("badlen", s, 1);

        $display("[TB] leading garbage with backpressure");
        tx_ready = 1'b0;
        pl_ready = 1'b0;
        clearBatch();
        s = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
        modelStream(s);
        applyStimulus(s, 0);
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (tx_valid) seen = 1;
        end
        checkOutput("bp_tx_valid_rise", seen, 1);
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_tx_valid_held", tx_valid, 1'b1);
            checkOutput("bp_tx_data_held", tx_data, 8'h06);
            checkOutput("bp_rx_ready_low", rx_ready, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            pl_ready = ~pl_ready;
        end
        pl_ready = 1'b1;
        waitQuiet();
        compareBatch("bp");

        $display("[TB] reset mid-frame");
        s = '{8'hA5, 8'h03, 8'h11};
        applyStimulus(s, 0);
        pulseReset();
        s = '{8'hA5, 8'h01, 8'h55, 8'h54};
        runBatch("after_rst", s, 0);

        $display("[TB] random frames");
        rand_ready = 1'b1;
        for (int batch = 0; batch < 5; batch++) begin
            s.delete();
            for (int f = 0; f < 8; f++) begin
                repeat ($urandom_range(0, 2)) begin
                    b = 8'($urandom);
                    s.push_back((b == 8'hA5) ? 8'h00 : b);
                end
                s.push_back(8'hA5);
                kind = $urandom_range(0, 7);
                if (kind == 0) begin
                    s.push_back(8'h00);
                end else if (kind == 1) begin
                    s.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
                end else begin
                    n = $urandom_range(1, MAX_LEN);
                    s.push_back(8'(n));
                    x = 8'(n);
                    for (int k = 0; k < n; k++) begin
                        b = 8'($urandom);
                        s.push_back(b);
                        x ^= b;
                    end
                    if (kind == 2) x ^= 8'($urandom_range(1, 255));
                    s.push_back(x);
                end
            end
            runBatch("random", s, 2);
        end
        rand_ready = 1'b0;
        tx_ready   = 1'b1;
        pl_ready   = 1'b1;

        $display("[TB] inter-byte timeout");
        clearBatch();
        s = '{8'hA5, 8'h02, 8'h11};
        applyStimulus(s, 0);
        seen = 0;
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            if (tx_valid) seen++;
        end
        checkOutput("to_no_early_resp", seen, 0);
        repeat (40) @(negedge clk);
        @(posedge clk);
        #1;
`ifdef SERIAL_FRAME_TIMEOUT_EN
        exp_err = exp_err + 1;
        checkOutput("to_tx_count", cap_tx.size(), 1);
        checkOutput("to_tx_byte", (cap_tx.size() > 0) ? 32'(cap_tx[0]) : 32'hFFFF_FFFF, 8'h15);
        checkOutput("to_frame_err_cycles", cap_ferr, 1);
        checkOutput("to_err_count", err_count, exp_err);
        checkOutput("to_back_idle", rx_ready && !tx_valid, 1'b1);
`else
        checkOutput("to_tx_count", cap_tx.size(), 0);
        checkOutput("to_frame_err_cycles", cap_ferr, 0);
        checkOutput("to_err_count", err_count, exp_err);
        checkOutput("to_still_waiting", rx_ready, 1'b1);
`endif
        pulseReset();

        $display("[TB] error counter saturation");
        s.delete();
        for (int f = 0; f < 260; f++) begin
            s.push_back(8'hA5);
            s.push_back(8'h00);
        end
        runBatch("saturate", s, 0);

        checkOutput("handshake_stability", stab_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_frame_codec.md
Name: serial_frame_codec

Overview:
- Sits between serial_interface and user logic.
- Consumes the received byte stream from serial_interface (its o_data/o_valid/o_ready side) and parses framed packets.
- Buffers each payload until its checksum is verified, then returns a one-byte ACK/NAK into serial_interface's transmit input (i_data/i_valid/i_ready).
- Replays verified payload bytes to user logic on a byte stream with a last flag.

Parameters:
- MAX_LEN, 16, maximum payload bytes per frame (1..255); payload buffer depth.
- SOF_BYTE, 8'hA5, start-of-frame marker.
- ACK_BYTE, 8'h06, response for a good frame.
- NAK_BYTE, 8'h15, response for a rejected frame.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  8  byte from serial_interface o_data
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  codec accepts rx byte
- tx_data  out  8  response byte to serial_interface i_data
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  serial_interface accepts tx byte
- pl_data  out  8  verified payload byte
- pl_valid  out  1  pl_data valid
- pl_last  out  1  final payload byte of frame
- pl_ready  in  1  user accepts payload byte
- frame_err  out  1  one-cycle pulse when a frame is rejected
- err_count  out  8  rejected-frame count, saturating at 255

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE; rx_ready=1; tx_valid=0; tx_data=0; pl_valid=0; pl_last=0; pl_data=0; frame_err=0; err_count=0; index/length/checksum registers cleared.
- Handshakes: a transfer occurs on a clk edge with valid&ready. tx_valid, tx_data, pl_valid, pl_data and pl_last are registered and held stable until accepted.
- Frame format: SOF_BYTE, LEN, LEN payload bytes, CSUM. CSUM = XOR of LEN and all payload bytes.
- rx_ready=1 in IDLE, LEN, PAYLOAD, CSUM; rx_ready=0 in RESP, DRAIN.
- FSM:
  - IDLE: accepted byte == SOF_BYTE -> LEN. Any other byte is discarded silently.
  - LEN: LEN==0 or LEN>MAX_LEN -> RESP with NAK. Otherwise store length, csum=LEN, idx=0, go to PAYLOAD.
  - PAYLOAD: buf[idx]=byte, csum^=byte, idx++. On idx==LEN-1 accepted -> CSUM.
  - CSUM: byte==csum -> RESP with ACK (good=1). Otherwise RESP with NAK (good=0).
  - RESP: tx_valid=1 from the cycle after entry. On handshake: good -> DRAIN with idx=0; otherwise -> IDLE.
  - DRAIN: pl_data=buf[idx], pl_valid=1, pl_last=(idx==LEN-1). On handshake idx++; after the last byte -> IDLE.
- Latency:
  - tx_valid rises 1 cycle after the CSUM (or invalid LEN) byte handshake.
  - pl_valid rises 1 cycle after the ACK handshake.
  - Back-to-back DRAIN: 1 byte per cycle while pl_ready=1.
- Errors: on each NAK decision, frame_err pulses for 1 cycle, coincident with the transition into RESP. err_count increments, saturating at 255 with no wrap.
- SOF_BYTE inside LEN/PAYLOAD/CSUM is treated as data, with no resync.
- Reset mid-frame or mid-DRAIN aborts immediately: buffered payload is lost and no response is sent.
- Buffer: indexed 0..MAX_LEN-1. Index width is clog2(MAX_LEN+1).

Optional Feature:
- Macro: SERIAL_FRAME_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on every rx handshake and whenever the state is IDLE/RESP/DRAIN.
  - In LEN/PAYLOAD/CSUM, reaching TIMEOUT_CYCLES-1 with no rx handshake forces RESP with NAK, pulses frame_err and increments err_count.
- Undefined: no counter exists; a partial frame waits indefinitely for the next byte.

Test Plan:
- Good frame: rx A5 03 11 22 33 03 -> tx 06; pl 11,22,33 with pl_last only on 33; frame_err never high; err_count 0.
- Bad checksum: rx A5 03 11 22 33 04 -> tx 15; no pl_valid; frame_err one pulse; err_count 1.
- Invalid length (MAX_LEN=16): rx A5 00 -> tx 15. Then rx A5 11 -> tx 15. Trailing non-A5 bytes are discarded; err_count 2.
- Leading garbage plus backpressure: rx 00 FF A5 01 7E 7F with tx_ready=0 for 5 cycles.
  - Required: tx_valid=1 and tx_data=06 held stable; rx_ready=0 throughout.
  - Then pl 7E with pl_last=1. With pl_ready toggling, each byte is presented exactly once.
- Reset mid-frame: assert rst after rx A5 03 11. All outputs return to reset values asynchronously. A subsequent good frame A5 01 55 54 yields tx 06 and pl 55.
- With SERIAL_FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=100: rx A5 02 11, then idle 100 cycles.
  - Required: tx 15, one frame_err pulse, err_count 1, FSM back in IDLE.
  - Without the macro, the same stimulus gives no response.
